fork_fflop_n: RTL and testbench

Parametrised N-way fork for the Valid/Retry handshake fabric. One input token is replicated to up to Outputs branches, each through its own 2-entry flop buffer, so data and Retry are registered on every branch.
- Adds a per-token multicast mask, so only selected branches receive the token.
- Adds an eager mode, where branches accept independently and the token retires once every selected branch has taken it.
- Sits between a single producer and multiple consumer pipelines, for example request broadcast to several units.

---
 rtl/fork_fflop_n.sv | 94 +++++++++
 tb/tb_fork_fflop_n.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fork_fflop_n.sv
// N-way Valid/Retry fork: each branch owns a 2-entry flop buffer so data and
// Retry are registered per branch; supports multicast masks and eager retirement.
module fork_fflop_n #(
    parameter int Size    = 8,
    parameter int Outputs = 2,
    parameter int Eager   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [Size-1:0]         inp,
    input  logic                    inp_Valid,
    input  logic [Outputs-1:0]      inp_Mask,
    output logic                    inp_Retry,
    output logic [Outputs*Size-1:0] out,
    output logic [Outputs-1:0]      out_Valid,
    input  logic [Outputs-1:0]      out_Retry
);

    logic [Outputs-1:0] full;
    logic [Outputs-1:0] push;
    logic [Outputs-1:0] pop;

    for (genvar i = 0; i < Outputs; i++) begin : g_branch
        logic [1:0]      count;
        logic [Size-1:0] head;
        logic [Size-1:0] tail;

        assign full[i]              = (count == 2'd2);
        assign out_Valid[i]         = (count != 2'd0);
        assign out[i*Size +: Size]  = head;
        assign pop[i]               = out_Valid[i] & ~out_Retry[i];

        // Push never coincides with count==2 and pop never with count==0,
        // so push+pop only happens at count==1 where the new token becomes head.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                count <= 2'd0;
                head  <= '0;
                tail  <= '0;
            end else begin
                case ({push[i], pop[i]})
                    2'b10: begin
                        if (count == 2'd0) begin
                            head  <= inp;
                            count <= 2'd1;
                        end else begin
                            tail  <= inp;
                            count <= 2'd2;
                        end
                    end
                    2'b01: begin
                        if (count == 2'd2) begin
                            head <= tail;
                        end
                        count <= count - 2'd1;
                    end
                    2'b11: begin
                        head <= inp;
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    if (Eager != 0) begin : g_eager
        logic [Outputs-1:0] done;
        logic [Outputs-1:0] pend;

        assign pend      = inp_Mask & ~done;
        assign push      = {Outputs{inp_Valid}} & pend & ~full;
        assign inp_Retry = |(pend & full);

        // done remembers which branches already took the token being held,
        // so a stalled token is never delivered twice to the same branch.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                done <= '0;
            end else if (inp_Valid && !inp_Retry) begin
                done <= '0;
            end else if (inp_Valid) begin
                done <= done | push;
            end
        end
    end else begin : g_lockstep
        logic blk;

        assign blk       = |(inp_Mask & full);
        assign push      = {Outputs{inp_Valid & ~blk}} & inp_Mask;
        assign inp_Retry = blk;
    end

endmodule

// File: tb/tb_fork_fflop_n.sv
// Directed self-checking bench: a 4-way eager fork plus 2-way eager and
// 2-way lockstep forks driven with identical stimulus.
module tb_fork_fflop_n;

    logic        clk;
    logic        reset;

    logic [7:0]  d4_inp;
    logic        d4_valid;
    logic [3:0]  d4_mask;
    logic        d4_retry;
    logic [31:0] d4_out;
    logic [3:0]  d4_ov;
    logic [3:0]  d4_or;

    logic [7:0]  t_inp;
    logic        t_valid;
    logic [1:0]  t_mask;
    logic [1:0]  t_or;
    logic        e_retry;
    logic [15:0] e_out;
    logic [1:0]  e_ov;
    logic        l_retry;
    logic [15:0] l_out;
    logic [1:0]  l_ov;

    int checks = 0;
    int errors = 0;

    fork_fflop_n #(.Size(8), .Outputs(4), .Eager(1)) u_d4 (
        .clk(clk), .reset(reset), .inp(d4_inp), .inp_Valid(d4_valid),
        .inp_Mask(d4_mask), .inp_Retry(d4_retry), .out(d4_out),
        .out_Valid(d4_ov), .out_Retry(d4_or)
    );

    fork_fflop_n #(.Size(8), .Outputs(2), .Eager(1)) u_eager (
        .clk(clk), .reset(reset), .inp(t_inp), .inp_Valid(t_valid),
        .inp_Mask(t_mask), .inp_Retry(e_retry), .out(e_out),
        .out_Valid(e_ov), .out_Retry(t_or)
    );

    fork_fflop_n #(.Size(8), .Outputs(2), .Eager(0)) u_lock (
        .clk(clk), .reset(reset), .inp(t_inp), .inp_Valid(t_valid),
        .inp_Mask(t_mask), .inp_Retry(l_retry), .out(l_out),
        .out_Valid(l_ov), .out_Retry(t_or)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset    = 1'b0;
        d4_inp   = '0; d4_valid = 1'b0; d4_mask = '0; d4_or = '0;
        t_inp    = '0; t_valid  = 1'b0; t_mask  = '0; t_or  = '0;
        #12;
        checks++;
        if (d4_ov !== 4'h0 || d4_out !== 32'h0 || d4_retry !== 1'b0) begin
            errors++;
            $display("FAIL reset_d4: got ov=%h out=%h retry=%b expected 0/0/0", d4_ov, d4_out, d4_retry);
        end
        checks++;
        if (e_ov !== 2'b00 || e_out !== 16'h0 || e_retry !== 1'b0) begin
            errors++;
            $display("FAIL reset_eager: got ov=%b out=%h retry=%b expected 0/0/0", e_ov, e_out, e_retry);
        end
        checks++;
        if (l_ov !== 2'b00 || l_out !== 16'h0 || l_retry !== 1'b0) begin
            errors++;
            $display("FAIL reset_lock: got ov=%b out=%h retry=%b expected 0/0/0", l_ov, l_out, l_retry);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        d4_mask = 4'hF;
        d4_or   = 4'h0;
        for (int k = 1; k <= 16; k++) begin
            d4_inp   = 8'(k);
            d4_valid = 1'b1;
            #1;
            checks++;
            if (d4_retry !== 1'b0) begin
                errors++;
                $display("FAIL stream_retry k=%0d: got %b expected 0", k, d4_retry);
            end
            if (k > 1) begin
                checks++;
                if (d4_ov !== 4'hF || d4_out !== {4{8'(k - 1)}}) begin
                    errors++;
                    $display("FAIL stream_out k=%0d: got ov=%h out=%h expected ov=f out=%h", k, d4_ov, d4_out, {4{8'(k - 1)}});
                end
            end
            tick();
        end
        d4_valid = 1'b0;
        #1;
        checks++;
        if (d4_ov !== 4'hF || d4_out !== {4{8'h10}}) begin
            errors++;
            $display("FAIL stream_last: got ov=%h out=%h expected ov=f out=10101010", d4_ov, d4_out);
        end
        tick();
        checks++;
        if (d4_ov !== 4'h0) begin
            errors++;
            $display("FAIL stream_drain: got ov=%h expected 0", d4_ov);
        end
    endtask

    task automatic test_eager_skew();
        t_mask = 2'b11; t_or = 2'b10;
        t_inp = 8'hA1; t_valid = 1'b1; #1;
        checks++;
        if (e_retry !== 1'b0 || l_retry !== 1'b0) begin
            errors++;
            $display("FAIL skew_a1_retry: got e=%b l=%b expected 0/0", e_retry, l_retry);
        end
        tick();
        t_inp = 8'hA2; #1;
        tick();
        t_inp = 8'hA3; #1;
        checks++;
        if (e_retry !== 1'b1 || l_retry !== 1'b1) begin
            errors++;
            $display("FAIL skew_a3_retry: got e=%b l=%b expected 1/1", e_retry, l_retry);
        end
        checks++;
        if (e_out[7:0] !== 8'hA2 || l_out[7:0] !== 8'hA2) begin
            errors++;
            $display("FAIL skew_b0_a2: got e=%h l=%h expected a2/a2", e_out[7:0], l_out[7:0]);
        end
        tick();
        checks++;
        if (e_ov !== 2'b11 || e_out[7:0] !== 8'hA3 || e_retry !== 1'b1) begin
            errors++;
            $display("FAIL skew_eager_b0_a3: got ov=%b b0=%h retry=%b expected 11/a3/1", e_ov, e_out[7:0], e_retry);
        end
        checks++;
        if (l_ov !== 2'b10 || l_retry !== 1'b1) begin
            errors++;
            $display("FAIL skew_lock_hold: got ov=%b retry=%b expected 10/1", l_ov, l_retry);
        end
        tick();
        checks++;
        if (e_ov !== 2'b10) begin
            errors++;
            $display("FAIL skew_no_dup: got ov=%b expected 10", e_ov);
        end
        t_or = 2'b00; #1;
        checks++;
        if (e_out[15:8] !== 8'hA1 || l_out[15:8] !== 8'hA1 || e_retry !== 1'b1) begin
            errors++;
            $display("FAIL skew_b1_a1: got e=%h l=%h retry=%b expected a1/a1/1", e_out[15:8], l_out[15:8], e_retry);
        end
        tick();
        checks++;
        if (e_retry !== 1'b0 || l_retry !== 1'b0 || e_out[15:8] !== 8'hA2 || l_ov !== 2'b10) begin
            errors++;
            $display("FAIL skew_release: got er=%b lr=%b b1=%h lov=%b expected 0/0/a2/10", e_retry, l_retry, e_out[15:8], l_ov);
        end
        tick();
        t_valid = 1'b0; #1;
        checks++;
        if (e_ov !== 2'b10 || e_out[15:8] !== 8'hA3) begin
            errors++;
            $display("FAIL skew_eager_final: got ov=%b b1=%h expected 10/a3", e_ov, e_out[15:8]);
        end
        checks++;
        if (l_ov !== 2'b11 || l_out !== 16'hA3A3) begin
            errors++;
            $display("FAIL skew_lock_both: got ov=%b out=%h expected 11/a3a3", l_ov, l_out);
        end
        tick();
        checks++;
        if (e_ov !== 2'b00 || l_ov !== 2'b00) begin
            errors++;
            $display("FAIL skew_drain: got e=%b l=%b expected 00/00", e_ov, l_ov);
        end
    endtask

    task automatic test_multicast();
        t_or = 2'b00;
        t_inp = 8'h11; t_mask = 2'b01; t_valid = 1'b1; #1;
        tick();
        t_inp = 8'h22; t_mask = 2'b10; #1;
        checks++;
        if (e_ov !== 2'b01 || e_out[7:0] !== 8'h11 || l_ov !== 2'b01 || l_out[7:0] !== 8'h11) begin
            errors++;
            $display("FAIL mcast_b0: got e=%b/%h l=%b/%h expected 01/11", e_ov, e_out[7:0], l_ov, l_out[7:0]);
        end
        tick();
        t_inp = 8'h33; t_mask = 2'b00; #1;
        checks++;
        if (e_ov !== 2'b10 || e_out[15:8] !== 8'h22 || l_ov !== 2'b10 || l_out[15:8] !== 8'h22) begin
            errors++;
            $display("FAIL mcast_b1: got e=%b/%h l=%b/%h expected 10/22", e_ov, e_out[15:8], l_ov, l_out[15:8]);
        end
        checks++;
        if (e_retry !== 1'b0 || l_retry !== 1'b0) begin
            errors++;
            $display("FAIL mcast_zero_retry: got e=%b l=%b expected 0/0", e_retry, l_retry);
        end
        tick();
        t_valid = 1'b0; #1;
        checks++;
        if (e_ov !== 2'b00 || l_ov !== 2'b00) begin
            errors++;
            $display("FAIL mcast_zero_out: got e=%b l=%b expected 00/00", e_ov, l_ov);
        end
    endtask

    task automatic test_full_boundary();
        t_mask = 2'b01; t_or = 2'b01;
        t_inp = 8'hB1; t_valid = 1'b1; #1;
        tick();
        t_inp = 8'hB2; #1;
        tick();
        t_inp = 8'hB3; t_or = 2'b00; #1;
        checks++;
        if (e_retry !== 1'b1 || l_retry !== 1'b1 || e_out[7:0] !== 8'hB1) begin
            errors++;
            $display("FAIL full_blocked: got er=%b lr=%b b0=%h expected 1/1/b1", e_retry, l_retry, e_out[7:0]);
        end
        tick();
        checks++;
        if (e_retry !== 1'b0 || l_retry !== 1'b0 || e_out[7:0] !== 8'hB2 || l_out[7:0] !== 8'hB2) begin
            errors++;
            $display("FAIL full_next: got er=%b lr=%b e=%h l=%h expected 0/0/b2/b2", e_retry, l_retry, e_out[7:0], l_out[7:0]);
        end
        tick();
        t_valid = 1'b0; #1;
        checks++;
        if (e_ov !== 2'b01 || e_out[7:0] !== 8'hB3 || l_ov !== 2'b01 || l_out[7:0] !== 8'hB3) begin
            errors++;
            $display("FAIL full_order: got e=%b/%h l=%b/%h expected 01/b3", e_ov, e_out[7:0], l_ov, l_out[7:0]);
        end
        tick();
        checks++;
        if (e_ov !== 2'b00 || l_ov !== 2'b00) begin
            errors++;
            $display("FAIL full_drain: got e=%b l=%b expected 00/00", e_ov, l_ov);
        end
    endtask

    task automatic test_async_reset();
        t_mask = 2'b11; t_or = 2'b10;
        t_inp = 8'hC1; t_valid = 1'b1; #1;
        tick();
        t_inp = 8'hC2; #1;
        tick();
        t_inp = 8'hC3; #1;
        tick();
        checks++;
        if (e_retry !== 1'b1 || e_ov !== 2'b11) begin
            errors++;
            $display("FAIL areset_setup: got retry=%b ov=%b expected 1/11", e_retry, e_ov);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (e_ov !== 2'b00 || e_retry !== 1'b0 || l_ov !== 2'b00 || l_retry !== 1'b0) begin
            errors++;
            $display("FAIL areset_now: got eov=%b er=%b lov=%b lr=%b expected 00/0/00/0", e_ov, e_retry, l_ov, l_retry);
        end
        t_valid = 1'b0;
        tick();
        reset = 1'b1;
        t_or = 2'b00; t_inp = 8'hD1; t_valid = 1'b1; #1;
        tick();
        t_valid = 1'b0; #1;
        checks++;
        if (e_ov !== 2'b11 || e_out !== 16'hD1D1 || l_ov !== 2'b11 || l_out !== 16'hD1D1) begin
            errors++;
            $display("FAIL areset_fresh: got e=%b/%h l=%b/%h expected 11/d1d1", e_ov, e_out, l_ov, l_out);
        end
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_streaming();
        test_eager_skew();
        test_multicast();
        test_full_boundary();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
